// File: rtl/video_out_pkg.sv
// Shared types and constants for the video output monitor: FSM state,
// slot-word field positions and the saturating 10-bit counter helper.
package video_out_pkg;

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] MAX_WIDTH = 10'd1023;

   localparam int SLOT_LSB = 13;
   localparam int SLOT_MSB = 16;
   // Only rgb[16:13] may be non-zero in a well-formed slot word.
   localparam logic [23:0] SLOT_MASK = 24'h01E000;

   typedef enum logic [1:0] {
      WAIT_LINE = 2'd0,
      ACTIVE    = 2'd1,
      DONE      = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == MAX_WIDTH) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/video_out_border_counter.sv
// Leading/trailing black-pixel counters for one de run; start_i marks the
// first pixel of a run, pix_en_i every later pixel of the same run.
module video_out_border_counter
   import video_out_pkg::*;
(
   input  logic             clk_vid,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic             pix_en_i,
   input  logic             pix_zero_i,
   output logic [CNT_W-1:0] lead_o,
   output logic [CNT_W-1:0] trail_o
);

   logic [CNT_W-1:0] lead_q, lead_d;
   logic [CNT_W-1:0] trail_q, trail_d;
   logic             seen_q, seen_d;

   always_comb begin
      lead_d  = lead_q;
      trail_d = trail_q;
      seen_d  = seen_q;
      if (start_i) begin
         lead_d  = CNT_W'(pix_zero_i);
         trail_d = CNT_W'(pix_zero_i);
         seen_d  = ~pix_zero_i;
      end else if (pix_en_i) begin
         if (pix_zero_i) begin
            trail_d = sat_inc(trail_q);
            if (!seen_q) lead_d = sat_inc(lead_q);
         end else begin
            // A lit pixel freezes the left border and restarts the right one.
            trail_d = '0;
            seen_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         lead_q  <= '0;
         trail_q <= '0;
         seen_q  <= 1'b0;
      end else begin
         lead_q  <= lead_d;
         trail_q <= trail_d;
         seen_q  <= seen_d;
      end
   end

   assign lead_o  = lead_q;
   assign trail_o = trail_q;

endmodule

// File: rtl/video_out_monitor.sv
// Line/frame monitor for the de/hsync/vsync/rgb scaler feed. Results are
// one-cycle strobes with held data; borders built only with VIDEO_OUT_MONITOR_BORDER_EN.
module video_out_monitor
   import video_out_pkg::*;
(
   input  logic             clk_vid,
   input  logic             reset_n,
   input  logic             vsync_in,
   input  logic             hsync_in,
   input  logic             de_in,
   input  logic [23:0]      rgb_in,
   output logic             line_valid,
   output logic [CNT_W-1:0] line_width,
   output logic [CNT_W-1:0] border_left,
   output logic [CNT_W-1:0] border_right,
   output logic [3:0]       slot,
   output logic             frame_valid,
   output logic [CNT_W-1:0] frame_height,
   output logic [2:0]       err,
   output state_t           dbg_state
);

   state_t           state_q, state_d;
   logic             prev_de_q, armed_q;
   logic [CNT_W-1:0] width_q, width_d;
   logic             sat_q, sat_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic             line_valid_q, line_valid_d, frame_valid_q, frame_valid_d;
   logic [CNT_W-1:0] line_width_q, line_width_d, frame_height_q, frame_height_d;
   logic [CNT_W-1:0] border_left_q, border_left_d, border_right_q, border_right_d;
   logic [3:0]       slot_q, slot_d;
   logic [2:0]       err_q, err_d;
   logic [CNT_W-1:0] lead, trail;
   logic             rise, start_line, pix_en, line_end;

   // armed_q stays low after reset until de_in is seen low, so a run cut by reset is never taken as a new line.
   assign rise       = de_in & ~prev_de_q & armed_q;
   assign start_line = rise & ((state_q == WAIT_LINE) | ((state_q == DONE) & hsync_in));
   assign pix_en     = (state_q == ACTIVE) & de_in & ~hsync_in;
   assign line_end   = (state_q == ACTIVE) & ~de_in & ~hsync_in;

`ifdef VIDEO_OUT_MONITOR_BORDER_EN
   video_out_border_counter u_border (
      .clk_vid    (clk_vid),
      .reset_n    (reset_n),
      .start_i    (start_line),
      .pix_en_i   (pix_en),
      .pix_zero_i (rgb_in == 24'd0),
      .lead_o     (lead),
      .trail_o    (trail)
   );
`else
   assign lead  = '0;
   assign trail = '0;
`endif

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) state_q <= WAIT_LINE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_LINE: if (start_line) state_d = ACTIVE;
         ACTIVE:    if (hsync_in) state_d = WAIT_LINE;
                    else if (!de_in) state_d = DONE;
         DONE:      if (hsync_in) state_d = start_line ? ACTIVE : WAIT_LINE;
         default:   state_d = WAIT_LINE;
      endcase
   end

   always_comb begin
      width_d        = width_q;
      sat_d          = sat_q;
      line_cnt_d     = line_cnt_q;
      line_valid_d   = 1'b0;
      frame_valid_d  = 1'b0;
      line_width_d   = line_width_q;
      border_left_d  = border_left_q;
      border_right_d = border_right_q;
      slot_d         = slot_q;
      frame_height_d = frame_height_q;
      err_d          = '0;
      if (start_line) begin
         width_d = CNT_W'(1);
         sat_d   = 1'b0;
      end else if (pix_en) begin
         if (width_q == MAX_WIDTH) begin
            err_d[2] = ~sat_q;
            sat_d    = 1'b1;
         end else begin
            width_d = width_q + CNT_W'(1);
         end
      end
      if (line_end) begin
         line_valid_d   = 1'b1;
         line_width_d   = width_q;
         border_left_d  = lead;
         border_right_d = trail;
         slot_d         = rgb_in[SLOT_MSB:SLOT_LSB];
         err_d[1]       = |(rgb_in & ~SLOT_MASK);
         line_cnt_d     = sat_inc(line_cnt_q);
      end
      if ((state_q == DONE) && rise && !hsync_in) err_d[0] = 1'b1;
      // A line closing on the vsync cycle still belongs to the ending frame.
      if (vsync_in) begin
         frame_valid_d  = 1'b1;
         frame_height_d = line_end ? sat_inc(line_cnt_q) : line_cnt_q;
         line_cnt_d     = '0;
      end
   end

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         prev_de_q      <= 1'b0;
         armed_q        <= 1'b0;
         width_q        <= '0;
         sat_q          <= 1'b0;
         line_cnt_q     <= '0;
         line_valid_q   <= 1'b0;
         frame_valid_q  <= 1'b0;
         line_width_q   <= '0;
         border_left_q  <= '0;
         border_right_q <= '0;
         slot_q         <= '0;
         frame_height_q <= '0;
         err_q          <= '0;
      end else begin
         prev_de_q      <= de_in;
         armed_q        <= armed_q | ~de_in;
         width_q        <= width_d;
         sat_q          <= sat_d;
         line_cnt_q     <= line_cnt_d;
         line_valid_q   <= line_valid_d;
         frame_valid_q  <= frame_valid_d;
         line_width_q   <= line_width_d;
         border_left_q  <= border_left_d;
         border_right_q <= border_right_d;
         slot_q         <= slot_d;
         frame_height_q <= frame_height_d;
         err_q          <= err_d;
      end
   end

   assign line_valid   = line_valid_q;
   assign line_width   = line_width_q;
   assign border_left  = border_left_q;
   assign border_right = border_right_q;
   assign slot         = slot_q;
   assign frame_valid  = frame_valid_q;
   assign frame_height = frame_height_q;
   assign err          = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_video_out_monitor.sv
// Bench for video_out_monitor: directed and random lines scored against a
// pixel-list reference model; border expectations follow VIDEO_OUT_MONITOR_BORDER_EN.
module tb_video_out_monitor;
   import video_out_pkg::*;

   logic        clk_vid = 1'b0;
   logic        reset_n = 1'b0;
   logic        vsync_in = 1'b0, hsync_in = 1'b0, de_in = 1'b0;
   logic [23:0] rgb_in = '0;
   logic        line_valid, frame_valid;
   logic [9:0]  line_width, border_left, border_right, frame_height;
   logic [3:0]  slot;
   logic [2:0]  err;
   state_t      dbg_state;

   int n_vec = 0, n_bad = 0;
   int cnt_lv = 0, cnt_e0 = 0, cnt_e1 = 0, cnt_e2 = 0;
   int exp_lv = 0, exp_e0 = 0, exp_e1 = 0, exp_e2 = 0;
   int lines_in_frame = 0;
   logic [23:0] pix_q[$];
   logic [34:0] exp_q[$];

   video_out_monitor dut (
      .clk_vid(clk_vid), .reset_n(reset_n), .vsync_in(vsync_in), .hsync_in(hsync_in),
      .de_in(de_in), .rgb_in(rgb_in), .line_valid(line_valid), .line_width(line_width),
      .border_left(border_left), .border_right(border_right), .slot(slot),
      .frame_valid(frame_valid), .frame_height(frame_height), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk_vid = ~clk_vid;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every line_valid strobe must match the oldest expected line.
   always @(negedge clk_vid) begin
      if (line_valid === 1'b1) begin
         cnt_lv++;
         chk("line_valid_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0)
            chk("line_record", {line_width, border_left, border_right, slot, err[1]}, exp_q.pop_front());
      end
      if (err[0] === 1'b1) cnt_e0++;
      if (err[1] === 1'b1) cnt_e1++;
      if (err[2] === 1'b1) cnt_e2++;
   end

   task automatic step();
      @(posedge clk_vid);
      #1;
   endtask

   task automatic fill_const(input int n, input logic [23:0] v);
      pix_q.delete();
      repeat (n) pix_q.push_back(v);
   endtask

   task automatic fill_rand(input int n, input int zero_pct);
      pix_q.delete();
      repeat (n) begin
         if ($urandom_range(0, 99) < zero_pct) pix_q.push_back(24'd0);
         else pix_q.push_back(24'($urandom_range(1, 24'hFFFFFF)));
      end
   endtask

   // Reference model: count the pixel list directly.
   function automatic logic [34:0] line_model(input logic [23:0] slot_word);
      int n, w, lead, trail;
      logic bad;
      n = pix_q.size();
      lead = 0;
      trail = 0;
      while (lead < n && pix_q[lead] == 24'd0) lead++;
      while (trail < n && pix_q[n-1-trail] == 24'd0) trail++;
      w = (n > 1023) ? 1023 : n;
      if (lead > 1023) lead = 1023;
      if (trail > 1023) trail = 1023;
`ifndef VIDEO_OUT_MONITOR_BORDER_EN
      lead = 0;
      trail = 0;
`endif
      bad = (slot_word[23:17] != 7'd0) || (slot_word[12:0] != 13'd0);
      return {10'(w), 10'(lead), 10'(trail), slot_word[16:13], bad};
   endfunction

   task automatic send_line(input logic [23:0] slot_word, input bit vs_at_fall, input bit hs_on_first);
      logic [34:0] e;
      if (!hs_on_first) begin
         hsync_in = 1'b1; de_in = 1'b0; rgb_in = '0;
         step();
         hsync_in = 1'b0;
         step();
      end
      e = line_model(slot_word);
      exp_q.push_back(e);
      exp_lv++;
      if (pix_q.size() > 1023) exp_e2++;
      if (e[0]) exp_e1++;
      foreach (pix_q[i]) begin
         de_in = 1'b1; rgb_in = pix_q[i]; hsync_in = hs_on_first && (i == 0);
         step();
      end
      hsync_in = 1'b0; de_in = 1'b0; rgb_in = slot_word; vsync_in = vs_at_fall;
      step();
      lines_in_frame++;
      chk("line_valid", line_valid, 1);
      chk("line_width", line_width, e[34:25]);
      chk("border_left", border_left, e[24:15]);
      chk("border_right", border_right, e[14:5]);
      chk("slot", slot, e[4:1]);
      chk("err_slot_word", err[1], e[0]);
      if (vs_at_fall) begin
         chk("frame_valid_at_fall", frame_valid, 1);
         chk("frame_height_at_fall", frame_height, lines_in_frame);
         lines_in_frame = 0;
      end
      vsync_in = 1'b0; rgb_in = '0;
      step();
      chk("line_valid_one_shot", line_valid, 0);
   endtask

   task automatic send_vsync();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      chk("frame_valid", frame_valid, 1);
      chk("frame_height", frame_height, lines_in_frame);
      lines_in_frame = 0;
      step();
      chk("frame_valid_one_shot", frame_valid, 0);
   endtask

   initial begin
      logic [31:0] r;
      logic [9:0]  held_width;

      // Reset state
      repeat (3) step();
      chk("rst_line_valid", line_valid, 0);
      chk("rst_outputs", {line_width, border_left, border_right, slot, frame_height}, 0);
      chk("rst_strobes", {frame_valid, err}, 0);
      reset_n = 1'b1;
      step();

      // Uniform line, clean slot 2
      fill_const(256, 24'h123456);
      send_line(24'h004000, 0, 0);

      // Black borders of 4 on each side, slot 4
      pix_q.delete();
      repeat (4) pix_q.push_back(24'd0);
      repeat (352) pix_q.push_back(24'hFFFFFF);
      repeat (4) pix_q.push_back(24'd0);
      send_line(24'h008000, 0, 0);

      // Bad slot word, then a second de run before hsync
      fill_rand(100, 0);
      send_line(24'h804000, 0, 0);
      held_width = line_width;
      de_in = 1'b1; rgb_in = 24'h0000FF;
      step();
      chk("err_second_run", err[0], 1);
      exp_e0++;
      repeat (9) step();
      chk("err_second_run_one_shot", err[0], 0);
      de_in = 1'b0; rgb_in = 24'h004000;
      step();
      rgb_in = '0;
      step();
      chk("second_run_no_line_valid", line_valid, 0);
      chk("second_run_width_held", line_width, held_width);

      // Line abandoned by hsync mid-run
      hsync_in = 1'b1; step(); hsync_in = 1'b0; step();
      de_in = 1'b1; rgb_in = 24'h111111;
      repeat (10) step();
      hsync_in = 1'b1; step(); hsync_in = 1'b0;
      repeat (3) step();
      de_in = 1'b0; step(); step();
      chk("abandoned_width_held", line_width, held_width);

      // Width saturation
      fill_rand(1100, 10);
      send_line(24'h002000, 0, 0);
      chk("err2_pulses_after_sat", cnt_e2, exp_e2);

      // Random lines with random slot words
      for (int k = 0; k < 10; k++) begin
         fill_rand($urandom_range(1, 40), 40);
         r = $urandom;
         send_line(($urandom_range(0, 1) != 0) ? r[23:0] : (r[23:0] & 24'h01E000), 0, 0);
      end

      // All-black line: borders equal width
      fill_const(30, 24'd0);
      send_line(24'h01E000, 0, 0);

      // hsync and de rise together from DONE
      fill_rand(12, 30);
      send_line(24'h006000, 0, 1);

      // Frame of 240 lines closed by vsync on the last de fall
      send_vsync();
      for (int k = 0; k < 240; k++) begin
         fill_rand(4, 30);
         send_line(24'h004000, k == 239, 0);
      end
      for (int k = 0; k < 3; k++) begin
         fill_rand(5, 20);
         send_line(24'h00A000, 0, 0);
      end
      send_vsync();

      // Reset asserted mid-run for one cycle
      fill_rand(6, 0);
      send_line(24'h004000, 0, 0);
      hsync_in = 1'b1; step(); hsync_in = 1'b0; step();
      de_in = 1'b1; rgb_in = 24'h777777;
      repeat (20) step();
      reset_n = 1'b0;
      step();
      chk("midrst_line_valid", line_valid, 0);
      chk("midrst_outputs", {line_width, border_left, border_right, slot, frame_height}, 0);
      chk("midrst_strobes", {frame_valid, err}, 0);
      reset_n = 1'b1;
      lines_in_frame = 0;
      repeat (5) step();
      de_in = 1'b0; rgb_in = 24'h004000;
      step();
      rgb_in = '0;
      step();
      chk("midrst_no_line_valid", line_valid, 0);
      fill_rand(20, 25);
      send_line(24'h01C000, 0, 0);
      send_vsync();

      // Final tallies
      step();
      chk("line_valid_count", cnt_lv, exp_lv);
      chk("pending_lines", exp_q.size(), 0);
      chk("err0_pulses", cnt_e0, exp_e0);
      chk("err1_pulses", cnt_e1, exp_e1);
      chk("err2_pulses", cnt_e2, exp_e2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
